fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Upstream write controller for the 16-deep, 8-bit FIFO. Accepts bytes from a producer over a valid/ready handshake and converts them into the FIFO's active-low `wr_n`/`data_in` write strobes. The FIFO exports no full/empty flags, so this block keeps a shadow occupancy count by observing the consumer's `rd_n`. It never issues a write the FIFO would reject, and it latches a fault if the FIFO ever reports `over_flow`.

## Interface
- `DATA_WIDTH`, 8: data bus width.
- `CAPACITY`, 15: usable FIFO entries. The FIFO flags full at a status count of 15.
- `LVL_W`, 5: width of the occupancy counter.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  allow the block to accept data (IDLE→RUN).
- `clr_fault`  in  1  single-cycle pulse; exits FAULT.
- `src_valid`  in  1  producer has a byte.
- `src_data`  in  DATA_WIDTH  producer byte.
- `src_ready`  out  1  block can take `src_data` this cycle.
- `rd_n_mon`  in  1  copy of the FIFO `rd_n` driven by the consumer.
- `over_flow`  in  1  FIFO overflow flag.
- `wr_n`  out  1  FIFO write strobe, active-low, registered.
- `wr_data`  out  DATA_WIDTH  to FIFO `data_in`, registered.
- `level`  out  LVL_W  shadow occupancy.
- `fault`  out  1  high while in FAULT.
- `wr_count`  out  16  committed writes, saturating at 16'hFFFF.

## Operation
- FSM states: IDLE, RUN, FAULT. Reset state is IDLE.
- IDLE→RUN: when `enable`=1.
- RUN→IDLE: when `enable`=0. Any write already registered still completes.
- RUN→FAULT: when `over_flow`=1 is sampled. This transition has priority over the `enable` transition.
- FAULT→IDLE: on `clr_fault`=1. `level` is not altered.
- `src_ready` is combinational from registers: `src_ready` = (state==RUN) && `enable` && (`level` + !`wr_n`) < `CAPACITY`.
  - The `!wr_n` term counts the in-flight write.
  - Reads in the same cycle are ignored (conservative).
- Accept: `src_valid` && `src_ready` at an edge. On that edge `wr_n` is set to 0 and `wr_data` is set to `src_data`.
  - If there is no accept, `wr_n` is set to 1 and `wr_data` holds its value.
- Committed write: `wr_n`=0 sampled at an edge. The FIFO samples the same edge.
- Committed read: `rd_n_mon`=0 && `level`≠0 sampled at an edge. A read at `level`=0 is an underflow and is ignored.
- `level` update per edge:
  - +1 on write only.
  - −1 on read only.
  - Unchanged when both occur or neither occurs.
- `level` never exceeds `CAPACITY` and never goes below 0.
- `wr_count` increments on each committed write and saturates.
- `level` and `wr_count` keep tracking in all states.
- In FAULT, `src_ready`=0 and no new writes are issued.

## Timing
- Reset values: state IDLE, `wr_n`=1, `wr_data`=0, `level`=0, `wr_count`=0, `fault`=0, `src_ready`=0.
- Latency: accept at edge N → `wr_n` low during cycle N+1 → FIFO write and `level`+1 at edge N+1.
- Back-to-back accepts are allowed, so the block sustains 1 byte per cycle until `level` + in-flight = `CAPACITY`.
- `src_ready` may drop in the cycle after an accept. The producer must hold `src_data` until the accept.
- `fault` rises the cycle after `over_flow` is sampled high.
- Reset asserted mid-write: `wr_n` goes to 1 immediately (asynchronous). The in-flight byte is lost and `level` is cleared to 0.

## Structure
- Shared package `fifo_pkg` holds:
  - `DATA_WIDTH`, `FIFO_DEPTH`, `PTR_SIZE`, `CAPACITY`.
  - `wr_ctrl_state_t` enum {IDLE, RUN, FAULT}.
- One sub-module: `fifo_level_tracker`.
  - Inputs: write-commit and read-commit.
  - Output: saturating `level`.
  - Reused later by the read-side controller.

## Test plan
- Reset, then `enable`=1 and 3 bytes A5,3C,FF sent back-to-back → `wr_n` low for 3 consecutive cycles starting one cycle after the first accept; `wr_data` carries A5,3C,FF; `level`=3; `wr_count`=3.
- 20 bytes offered with no reads → exactly 15 writes occur; `src_ready`=0 once `level`=14 with one write in flight; `level`=15; the FIFO never raises `over_flow`.
- `level`=15, then one `rd_n_mon` pulse → `level`=14 and `src_ready` returns to 1; a simultaneous read and write at `level`=8 leaves `level`=8.
- `rd_n_mon`=0 at `level`=0 → `level` stays 0 and `wr_count` is unchanged.
- `over_flow` forced high in RUN → `fault`=1 next cycle and `src_ready`=0; `clr_fault` pulse → IDLE; `enable` held at 1 → RUN on the following edge.
- `rst_n` asserted during a burst (`level`=6) → `wr_n`=1 asynchronously; after release, `level`=0, `wr_count`=0 and state is IDLE.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the 16-deep, 8-bit FIFO and its side controllers.
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int PTR_SIZE   = 4;
    // The FIFO reports full at 15 entries, so one slot is never usable.
    localparam int CAPACITY   = FIFO_DEPTH - 1;
    localparam int LVL_W      = PTR_SIZE + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } wr_ctrl_state_t;

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Producer handshake, FIFO write strobes and status for the FIFO write controller.
interface fifo_wr_ctrl_if #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int LVL_W      = fifo_pkg::LVL_W
);
    logic                  enable;
    logic                  clr_fault;
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;
    logic                  rd_n_mon;
    logic                  over_flow;
    logic                  wr_n;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [LVL_W-1:0]      level;
    logic                  fault;
    logic [15:0]           wr_count;

    modport slave (
        input  enable, clr_fault, src_valid, src_data, rd_n_mon, over_flow,
        output src_ready, wr_n, wr_data, level, fault, wr_count
    );

    modport master (
        output enable, clr_fault, src_valid, src_data, rd_n_mon, over_flow,
        input  src_ready, wr_n, wr_data, level, fault, wr_count
    );
endinterface

// File: rtl/fifo_level_tracker.sv
// Shadow occupancy of the FIFO from observed write/read strobes; never wraps.
module fifo_level_tracker
    import fifo_pkg::*;
#(
    parameter int LVL_W    = fifo_pkg::LVL_W,
    parameter int CAPACITY = fifo_pkg::CAPACITY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_commit_i,
    input  logic             rd_req_i,
    output logic [LVL_W-1:0] level_o
);

    logic [LVL_W-1:0] level_q, level_d;
    logic             rd_commit;

    // A read request against an empty FIFO is an underflow and does not count.
    assign rd_commit = rd_req_i && (level_q != '0);

    always_comb begin
        level_d = level_q;
        if (wr_commit_i && !rd_commit && (level_q < LVL_W'(CAPACITY)))
            level_d = level_q + 1'b1;
        else if (rd_commit && !wr_commit_i)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_q <= '0;
        else        level_q <= level_d;
    end

    assign level_o = level_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Upstream write controller: valid/ready producer in, registered wr_n/data_in strobes out.
module fifo_wr_ctrl #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int CAPACITY   = fifo_pkg::CAPACITY,
    parameter int LVL_W      = fifo_pkg::LVL_W
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_wr_ctrl_if.slave bus
);
    import fifo_pkg::*;

    wr_ctrl_state_t        state_q;
    logic                  wr_n_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  fault_q;
    logic [15:0]           wr_count_q;
    logic [LVL_W-1:0]      level;
    logic [LVL_W:0]        occ;
    logic                  wr_commit;
    logic                  ready;
    logic                  accept;

    assign wr_commit = !wr_n_q;

    // The write already on the strobe is not in level yet, so reserve its slot.
    assign occ    = {1'b0, level} + {{LVL_W{1'b0}}, wr_commit};
    assign ready  = (state_q == RUN) && bus.enable && (occ < (LVL_W+1)'(CAPACITY));
    assign accept = bus.src_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_n_q     <= 1'b1;
            wr_data_q  <= '0;
            fault_q    <= 1'b0;
            wr_count_q <= '0;
        end else begin
            wr_n_q <= !accept;
            if (accept)
                wr_data_q <= bus.src_data;
            if (wr_commit && (wr_count_q != 16'hFFFF))
                wr_count_q <= wr_count_q + 16'd1;

            case (state_q)
                IDLE: begin
                    if (bus.enable) state_q <= RUN;
                end
                RUN: begin
                    // Overflow wins over a simultaneous disable.
                    if (bus.over_flow) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                    end else if (!bus.enable) begin
                        state_q <= IDLE;
                    end
                end
                FAULT: begin
                    if (bus.clr_fault) begin
                        state_q <= IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    fifo_level_tracker #(
        .LVL_W    (LVL_W),
        .CAPACITY (CAPACITY)
    ) u_level (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_commit_i (wr_commit),
        .rd_req_i    (!bus.rd_n_mon),
        .level_o     (level)
    );

    assign bus.src_ready = ready;
    assign bus.wr_n      = wr_n_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.level     = level;
    assign bus.fault     = fault_q;
    assign bus.wr_count  = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_wr_ctrl;

    localparam int CAP = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_ctrl_if ifc ();

    fifo_wr_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bytes accepted but not yet strobed, and bytes resident in the FIFO.
    typedef enum {M_IDLE, M_RUN, M_FAULT} mst_t;
    mst_t       m_st;
    int         m_cnt;
    logic [7:0] m_data;
    logic [7:0] inflight[$];
    logic [7:0] fifo_q[$];

    function automatic bit m_ready();
        return (m_st == M_RUN) && (ifc.enable === 1'b1) &&
               ((fifo_q.size() + inflight.size()) < CAP);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st   = M_IDLE;
            m_cnt  = 0;
            m_data = '0;
            inflight.delete();
            fifo_q.delete();
        end else begin
            bit w, r, acc;
            w   = inflight.size() != 0;
            r   = (ifc.rd_n_mon == 1'b0) && (fifo_q.size() != 0);
            acc = ifc.src_valid && m_ready();
            if (r) void'(fifo_q.pop_front());
            if (w) begin
                if (chk_en) chk("fifo_no_overrun", fifo_q.size() < CAP, 1);
                fifo_q.push_back(inflight.pop_front());
                if (m_cnt < 65535) m_cnt++;
            end
            if (acc) begin
                inflight.push_back(ifc.src_data);
                m_data = ifc.src_data;
            end
            case (m_st)
                M_IDLE:  if (ifc.enable) m_st = M_RUN;
                M_RUN:   if (ifc.over_flow) m_st = M_FAULT;
                         else if (!ifc.enable) m_st = M_IDLE;
                M_FAULT: if (ifc.clr_fault) m_st = M_IDLE;
                default: m_st = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("src_ready", ifc.src_ready, m_ready());
            chk("wr_n",      ifc.wr_n,      inflight.size() == 0);
            chk("wr_data",   ifc.wr_data,   m_data);
            chk("level",     ifc.level,     fifo_q.size());
            chk("fault",     ifc.fault,     m_st == M_FAULT);
            chk("wr_count",  ifc.wr_count,  m_cnt);
        end
    end

    bit         rec = 1'b0;
    bit         wr_log[$];
    logic [7:0] dat_log[$];
    always @(negedge clk) begin
        if (rec) begin
            wr_log.push_back(ifc.wr_n);
            dat_log.push_back(ifc.wr_data);
        end
    end

    logic [7:0] tx_q[$];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer tx_q in order, holding each byte until accepted; call at negedge+1.
    task automatic send(input int budget, output int n_acc);
        n_acc = 0;
        for (int c = 0; c < budget && tx_q.size() > 0; c++) begin
            ifc.src_valid = 1'b1;
            ifc.src_data  = tx_q[0];
            #1;
            if (ifc.src_ready) begin
                void'(tx_q.pop_front());
                n_acc++;
            end
            tick();
        end
        ifc.src_valid = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  hold;
        ifc.enable    = 1'b0;
        ifc.clr_fault = 1'b0;
        ifc.src_valid = 1'b0;
        ifc.src_data  = '0;
        ifc.rd_n_mon  = 1'b1;
        ifc.over_flow = 1'b0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        tick();
        chk("rst_wr_n", ifc.wr_n, 1);
        chk("rst_wr_data", ifc.wr_data, 0);
        chk("rst_level", ifc.level, 0);
        chk("rst_src_ready", ifc.src_ready, 0);
        chk("rst_fault", ifc.fault, 0);
        chk("rst_wr_count", ifc.wr_count, 0);
        rst_n = 1'b1;
        tick();

        // Three back-to-back bytes.
        ifc.enable = 1'b1;
        tick();
        tx_q = '{8'hA5, 8'h3C, 8'hFF};
        rec  = 1'b1;
        send(10, n);
        tick();
        tick();
        rec = 1'b0;
        chk("burst3_accepts", n, 3);
        chk("burst3_wr_n0", wr_log[0], 0);
        chk("burst3_wr_n1", wr_log[1], 0);
        chk("burst3_wr_n2", wr_log[2], 0);
        chk("burst3_wr_n3", wr_log[3], 1);
        chk("burst3_d0", dat_log[0], 8'hA5);
        chk("burst3_d1", dat_log[1], 8'h3C);
        chk("burst3_d2", dat_log[2], 8'hFF);
        chk("burst3_level", ifc.level, 3);
        chk("burst3_wr_count", ifc.wr_count, 3);

        // Twenty bytes offered, no reads: only 15 fit.
        do_reset();
        tick();
        tx_q.delete();
        for (int i = 0; i < 20; i++) tx_q.push_back(8'(i * 7 + 1));
        send(40, n);
        tick();
        chk("fill_accepts", n, 15);
        chk("fill_level", ifc.level, 15);
        chk("fill_wr_count", ifc.wr_count, 15);
        chk("fill_src_ready", ifc.src_ready, 0);
        tx_q.delete();

        // One read frees a slot; then read down to 8 and overlap a read with a write.
        ifc.rd_n_mon = 1'b0;
        tick();
        ifc.rd_n_mon = 1'b1;
        chk("read1_level", ifc.level, 14);
        chk("read1_src_ready", ifc.src_ready, 1);
        ifc.rd_n_mon = 1'b0;
        repeat (6) tick();
        ifc.rd_n_mon = 1'b1;
        chk("drain_level", ifc.level, 8);
        ifc.src_valid = 1'b1;
        ifc.src_data  = 8'h5A;
        tick();
        ifc.src_valid = 1'b0;
        ifc.rd_n_mon  = 1'b0;
        tick();
        ifc.rd_n_mon  = 1'b1;
        chk("rw_same_level", ifc.level, 8);
        chk("rw_same_wr_count", ifc.wr_count, 16);

        // Underflow reads at level 0.
        do_reset();
        ifc.rd_n_mon = 1'b0;
        repeat (4) tick();
        ifc.rd_n_mon = 1'b1;
        chk("underflow_level", ifc.level, 0);
        chk("underflow_wr_count", ifc.wr_count, 0);

        // Overflow in RUN, then clear back through IDLE.
        ifc.over_flow = 1'b1;
        tick();
        ifc.over_flow = 1'b0;
        chk("ovf_fault", ifc.fault, 1);
        chk("ovf_src_ready", ifc.src_ready, 0);
        ifc.src_valid = 1'b1;
        ifc.src_data  = 8'h77;
        tick();
        ifc.src_valid = 1'b0;
        ifc.clr_fault = 1'b1;
        tick();
        ifc.clr_fault = 1'b0;
        chk("clr_fault", ifc.fault, 0);
        chk("clr_idle_ready", ifc.src_ready, 0);
        tick();
        chk("clr_run_ready", ifc.src_ready, 1);
        chk("fault_no_write", ifc.wr_count, 0);

        // Reset in the middle of a burst.
        tx_q.delete();
        for (int i = 0; i < 10; i++) tx_q.push_back(8'(8'h40 + i));
        send(7, n);
        chk("midrst_level_pre", ifc.level, 6);
        chk("midrst_wr_n_pre", ifc.wr_n, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_n_async", ifc.wr_n, 1);
        chk("midrst_level_async", ifc.level, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("postrst_level", ifc.level, 0);
        chk("postrst_wr_count", ifc.wr_count, 0);
        chk("postrst_idle_ready", ifc.src_ready, 0);
        tx_q.delete();
        tick();

        // Random traffic: a fill-heavy phase, then a balanced phase.
        hold = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            ifc.enable    = ($urandom_range(0, 24) != 0);
            ifc.rd_n_mon  = (c < 500) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0);
            ifc.over_flow = ($urandom_range(0, 149) == 0);
            ifc.clr_fault = ifc.fault && ($urandom_range(0, 3) == 0);
            if (!hold) begin
                ifc.src_valid = ($urandom_range(0, 3) != 0);
                ifc.src_data  = 8'($urandom);
            end
            #1;
            hold = ifc.src_valid && !ifc.src_ready;
            tick();
        end
        ifc.src_valid = 1'b0;
        ifc.over_flow = 1'b0;
        ifc.clr_fault = 1'b0;
        ifc.rd_n_mon  = 1'b1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
